decode_regfile: RTL and testbench
=================================

# decode_regfile

Parametrised Y86-64 decode stage with an integrated, resettable register file. It selects source registers from `icode`/`rA`/`rB`, reads two operands, and presents them through a one-entry registered output stage with valid/ready handshakes on both sides. It accepts two independent write-back ports, E from execute and M from memory. It sits between fetch and execute and generalises the fixed 64-bit, 15-register, write-less decode block in width, depth, write-back and flow control.

## Interface
Parameters:
- `DATA_W`, 64: register and operand width.
- `NREGS`, 15: number of implemented registers, indices 0..NREGS-1, with `NREGS` ≤ 15.
- `RSP_IDX`, 4: stack-pointer register index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  decode can accept the instruction this cycle.
- `icode`  in  4  instruction code.
- `rA`  in  4  register field A.
- `rB`  in  4  register field B.
- `we_e`, `dst_e`, `val_e`  in  1/4/DATA_W  E write-back port.
- `we_m`, `dst_m`, `val_m`  in  1/4/DATA_W  M write-back port.
- `out_valid`  out  1  decoded operands are valid.
- `out_ready`  in  1  execute accepts the decoded operands.
- `out_icode`  out  4  registered `icode`.
- `src_a`, `src_b`  out  4  registered source indices; 0xF means none.
- `val_a`, `val_b`  out  DATA_W  registered operands.
- `ins_err`  out  1  registered flag: `icode` was greater than 0xB.

## Operation
- Source select, combinational from inputs:
  - `src_a` = rA for cmovXX (2), rmmovq (4), OPq (6) and pushq (A).
  - `src_a` = RSP_IDX for popq (B) and ret (9).
  - Otherwise `src_a` = 0xF.
  - `src_b` = rB for rmmovq, mrmovq (5) and OPq.
  - `src_b` = RSP_IDX for pushq, popq, call (8) and ret.
  - Otherwise `src_b` = 0xF. irmovq reads nothing.
- Read rules:
  - An index of 0xF or ≥ NREGS returns 0.
  - Otherwise the read returns the register contents, subject to the bypass in Configuration.
- Write rules:
  - A write happens on the rising edge when `we_x` = 1 and `dst_x` < NREGS.
  - A `dst` of 0xF, or any other index ≥ NREGS, is ignored.
  - When E and M both write the same register, M wins. This preserves `popq %rsp` semantics.
  - Writes proceed regardless of handshake state.
- Handshake:
  - `in_ready = !out_valid || out_ready`.
  - Transfer occurs when `in_valid && in_ready`. On transfer the output stage loads `out_icode`, `src_a`, `src_b`, `val_a`, `val_b` and `ins_err`, and sets `out_valid` = 1.
  - When `out_valid && out_ready && !in_valid`, `out_valid` clears to 0. The data outputs hold their last values.
  - When `out_valid && !out_ready`, all outputs hold. Operands captured earlier are not refreshed by later writes; hazard control is the pipeline controller's job.
- An invalid `icode` still transfers, with `src_a` = `src_b` = 0xF, both operands 0, and `ins_err` = 1.

## Timing
- Reset, asynchronous, active while `rst_n` = 0:
  - Register i = i, zero-extended to DATA_W.
  - `out_valid` = 0, `val_a` = `val_b` = 0, `src_a` = `src_b` = 0xF, `out_icode` = 0, `ins_err` = 0.
  - `in_ready` = 1 combinationally.
- Reset asserted mid-operation discards the held output entry and any write presented in that cycle.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N. Throughput is 1 per cycle when `out_ready` stays 1.
- A write at edge N is visible to a read accepted at edge N+1 or later.
- A same-edge write and read is governed by `DECODE_BYPASS_EN`.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A read whose index matches an active write in the same cycle returns the write data, with M taking priority over E.
  - The bypass applies to both `val_a` and `val_b` at capture.
- `DECODE_BYPASS_EN` undefined: same-cycle reads return the pre-write register value. This is pure read-before-write behaviour.

## Test plan
- Reset, then OPq with rA=1, rB=2 and `out_ready`=1 → one cycle later `out_valid`=1, `val_a`=1, `val_b`=2, `src_a`=1, `src_b`=2.
- pushq rA=3, then popq → first output `val_a`=3, `val_b`=4; second output `val_a`=4, `val_b`=4, `src_a`=`src_b`=4.
- OPq rA=5 in the same cycle as `we_e`=1, `dst_e`=5, `val_e`=0xDEAD → `val_a`=0xDEAD with the macro defined, `val_a`=5 without it; a following read returns 0xDEAD in both builds.
- `we_e`/`we_m` both targeting reg 4 with E=0x10 and M=0x20 → reg 4 reads 0x20. A write to `dst`=0xF changes nothing.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable, no instruction lost; on release the queued instruction appears one cycle later.
- `icode`=0xC → `ins_err`=1 and operands 0. Pulse `rst_n` low mid-stall → `out_valid`=0 immediately and registers return to their index values.

Source files
------------

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: source select, resettable register file with E/M write-back, one-entry output register.
// Latency 1 cycle; in_ready = !out_valid || out_ready, stalled outputs hold. DECODE_BYPASS_EN forwards same-cycle writes.
module decode_regfile #(
  parameter int DATA_W  = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              we_e,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic              we_m,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [3:0]        src_a,
  output logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  output logic              ins_err
);

  localparam logic [3:0] LP_NREGS = 4'(NREGS);
  localparam logic [3:0] LP_RSP   = 4'(RSP_IDX);
  localparam logic [3:0] LP_NONE  = 4'hF;

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_out_valid;
  logic [3:0]        r_out_icode;
  logic [3:0]        r_src_a;
  logic [3:0]        r_src_b;
  logic [DATA_W-1:0] r_val_a;
  logic [DATA_W-1:0] r_val_b;
  logic              r_ins_err;

  logic [3:0]        w_src_a;
  logic [3:0]        w_src_b;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_wr_e;
  logic              w_wr_m;
  logic              w_xfer;
  logic              w_ins_err;

  // Invalid icodes fall through to the default and read nothing.
  always_comb begin
    w_src_a = LP_NONE;
    w_src_b = LP_NONE;
    case (icode)
      I_CMOV:  w_src_a = rA;
      I_RMMOV,
      I_OP: begin
        w_src_a = rA;
        w_src_b = rB;
      end
      I_MRMOV: w_src_b = rB;
      I_PUSH: begin
        w_src_a = rA;
        w_src_b = LP_RSP;
      end
      I_POP,
      I_RET: begin
        w_src_a = LP_RSP;
        w_src_b = LP_RSP;
      end
      I_CALL:  w_src_b = LP_RSP;
      default: ;
    endcase
  end

  assign w_ins_err = (icode > 4'hB);
  assign w_wr_e    = we_e && (dst_e < LP_NREGS);
  assign w_wr_m    = we_m && (dst_m < LP_NREGS);

  // Unimplemented indices (including 0xF) match no register and read as zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_src_a == 4'(i)) w_rd_a = r_regs[i];
      if (w_src_b == 4'(i)) w_rd_b = r_regs[i];
    end
`ifdef DECODE_BYPASS_EN
    if (w_wr_e && (dst_e == w_src_a)) w_rd_a = val_e;
    if (w_wr_m && (dst_m == w_src_a)) w_rd_a = val_m;
    if (w_wr_e && (dst_e == w_src_b)) w_rd_b = val_e;
    if (w_wr_m && (dst_m == w_src_b)) w_rd_b = val_m;
`endif
  end

  // M is applied last so it wins a same-register collision (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= DATA_W'(i);
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_m && (dst_m == 4'(i)))      r_regs[i] <= val_m;
        else if (w_wr_e && (dst_e == 4'(i))) r_regs[i] <= val_e;
      end
    end
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_icode <= 4'h0;
      r_src_a     <= LP_NONE;
      r_src_b     <= LP_NONE;
      r_val_a     <= '0;
      r_val_b     <= '0;
      r_ins_err   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_icode <= icode;
      r_src_a     <= w_src_a;
      r_src_b     <= w_src_b;
      r_val_a     <= w_rd_a;
      r_val_b     <= w_rd_b;
      r_ins_err   <= w_ins_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_icode = r_out_icode;
  assign src_a     = r_src_a;
  assign src_b     = r_src_b;
  assign val_a     = r_val_a;
  assign val_b     = r_val_b;
  assign ins_err   = r_ins_err;

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: constant-vector table, hand sequences and randomized traffic against a reference model.
module tb_decode_regfile;
  localparam int DW  = 64;
  localparam int NR  = 15;
  localparam int RSP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    icode, rA, rB;
  logic          we_e, we_m;
  logic [3:0]    dst_e, dst_m;
  logic [DW-1:0] val_e, val_m;
  logic          out_valid, out_ready;
  logic [3:0]    out_icode, src_a, src_b;
  logic [DW-1:0] val_a, val_b;
  logic          ins_err;

  always #5 clk = ~clk;

  decode_regfile #(.DATA_W(DW), .NREGS(NR), .RSP_IDX(RSP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .rA(rA), .rB(rB),
    .we_e(we_e), .dst_e(dst_e), .val_e(val_e),
    .we_m(we_m), .dst_m(dst_m), .val_m(val_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .src_a(src_a), .src_b(src_b), .val_a(val_a), .val_b(val_b), .ins_err(ins_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_regs [NR];
  logic          m_valid;
  logic [3:0]    m_icode, m_sa, m_sb;
  logic [DW-1:0] m_va, m_vb;
  logic          m_err;

  typedef struct {
    logic [3:0]    ic, ra, rb, sa, sb;
    logic [DW-1:0] va, vb;
    logic          err;
  } vec_t;
  vec_t tbl [16];

`ifdef DECODE_BYPASS_EN
  localparam logic [DW-1:0] BYP_EXP = 64'hDEAD;
`else
  localparam logic [DW-1:0] BYP_EXP = 64'h5;
`endif

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] f_src_a(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB:             return 4'(RSP);
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] f_src_b(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6:       return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'(RSP);
      default:                return 4'hF;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_read(input logic [3:0] idx);
    logic [DW-1:0] v;
    v = '0;
    if (int'(idx) < NR) v = m_regs[idx];
`ifdef DECODE_BYPASS_EN
    if (we_e && int'(dst_e) < NR && dst_e == idx) v = val_e;
    if (we_m && int'(dst_m) < NR && dst_m == idx) v = val_m;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = DW'(i);
    m_valid = 1'b0; m_icode = 4'h0; m_sa = 4'hF; m_sb = 4'hF;
    m_va = '0; m_vb = '0; m_err = 1'b0;
  endtask

  task automatic check_outs();
    chk("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
    chk("out_icode", {60'b0, out_icode}, {60'b0, m_icode});
    chk("src_a", {60'b0, src_a}, {60'b0, m_sa});
    chk("src_b", {60'b0, src_b}, {60'b0, m_sb});
    chk("val_a", val_a, m_va);
    chk("val_b", val_b, m_vb);
    chk("ins_err", {63'b0, ins_err}, {63'b0, m_err});
  endtask

  task automatic set_in(input logic iv, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic ordy);
    in_valid = iv; icode = ic; rA = ra; rB = rb; out_ready = ordy;
  endtask

  task automatic set_wr(input logic e, input logic [3:0] de, input logic [DW-1:0] ve,
                        input logic m, input logic [3:0] dm, input logic [DW-1:0] vm);
    we_e = e; dst_e = de; val_e = ve; we_m = m; dst_m = dm; val_m = vm;
  endtask

  // One clock: predict from the current inputs, advance the model, then compare after the edge.
  task automatic tick();
    logic rdy;
    #1;
    rdy = !m_valid || out_ready;
    chk("in_ready", {63'b0, in_ready}, {63'b0, rdy});
    if (in_valid && rdy) begin
      m_icode = icode;
      m_sa    = f_src_a(icode, rA);
      m_sb    = f_src_b(icode, rB);
      m_va    = f_read(m_sa);
      m_vb    = f_read(m_sb);
      m_err   = (icode > 4'hB);
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (we_e && int'(dst_e) < NR) m_regs[dst_e] = val_e;
    if (we_m && int'(dst_m) < NR) m_regs[dst_m] = val_m;
    @(posedge clk); #1;
    check_outs();
  endtask

  initial begin
    tbl[0]  = '{4'h6, 4'h1, 4'h2, 4'h1, 4'h2, 64'h1, 64'h2, 1'b0};
    tbl[1]  = '{4'h2, 4'h3, 4'h7, 4'h3, 4'hF, 64'h3, 64'h0, 1'b0};
    tbl[2]  = '{4'h3, 4'hF, 4'h5, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0};
    tbl[3]  = '{4'h4, 4'h6, 4'h8, 4'h6, 4'h8, 64'h6, 64'h8, 1'b0};
    tbl[4]  = '{4'h5, 4'h9, 4'hA, 4'hF, 4'hA, 64'h0, 64'hA, 1'b0};
    tbl[5]  = '{4'hA, 4'h3, 4'hF, 4'h3, 4'h4, 64'h3, 64'h4, 1'b0};
    tbl[6]  = '{4'hB, 4'h3, 4'hF, 4'h4, 4'h4, 64'h4, 64'h4, 1'b0};
    tbl[7]  = '{4'h8, 4'h1, 4'h1, 4'hF, 4'h4, 64'h0, 64'h4, 1'b0};
    tbl[8]  = '{4'h9, 4'h1, 4'h1, 4'h4, 4'h4, 64'h4, 64'h4, 1'b0};
    tbl[9]  = '{4'h7, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0};
    tbl[10] = '{4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0};
    tbl[11] = '{4'h1, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0};
    tbl[12] = '{4'hC, 4'h1, 4'h2, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1};
    tbl[13] = '{4'hF, 4'h4, 4'h4, 4'hF, 4'hF, 64'h0, 64'h0, 1'b1};
    tbl[14] = '{4'h6, 4'hF, 4'hE, 4'hF, 4'hE, 64'h0, 64'hE, 1'b0};
    tbl[15] = '{4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, 1'b0};

    rst_n = 1'b0;
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    set_wr(1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
    model_reset();
    #12;
    chk("reset_in_ready", {63'b0, in_ready}, 64'h1);
    check_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, tbl[i].ic, tbl[i].ra, tbl[i].rb, 1'b1);
      tick();
      chk("tbl_src_a", {60'b0, src_a}, {60'b0, tbl[i].sa});
      chk("tbl_src_b", {60'b0, src_b}, {60'b0, tbl[i].sb});
      chk("tbl_val_a", val_a, tbl[i].va);
      chk("tbl_val_b", val_b, tbl[i].vb);
      chk("tbl_ins_err", {63'b0, ins_err}, {63'b0, tbl[i].err});
    end

    // pushq then popq back to back
    set_in(1'b1, 4'hA, 4'h3, 4'hF, 1'b1); tick();
    chk("push_val_a", val_a, 64'h3); chk("push_val_b", val_b, 64'h4);
    set_in(1'b1, 4'hB, 4'hF, 4'hF, 1'b1); tick();
    chk("pop_val_a", val_a, 64'h4); chk("pop_val_b", val_b, 64'h4);
    chk("pop_srcs", {56'b0, src_a, src_b}, 64'h44);

    // same-cycle write and read of reg 5
    set_wr(1'b1, 4'h5, 64'hDEAD, 1'b0, 4'h0, '0);
    set_in(1'b1, 4'h6, 4'h5, 4'hF, 1'b1); tick();
    chk("bypass_val_a", val_a, BYP_EXP);
    set_wr(1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
    tick();
    chk("after_write_val_a", val_a, 64'hDEAD);

    // E/M collision on reg 4, then writes to index 0xF
    set_wr(1'b1, 4'h4, 64'h10, 1'b1, 4'h4, 64'h20);
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b1); tick();
    set_wr(1'b1, 4'hF, 64'h99, 1'b1, 4'hF, 64'h77); tick();
    set_wr(1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
    for (int r = 0; r < NR; r++) begin
      set_in(1'b1, 4'h6, 4'(r), 4'(r), 1'b1); tick();
      chk("sweep_val_a", val_a, (r == 4) ? 64'h20 : (r == 5) ? 64'hDEAD : 64'(r));
    end

    // stall for three cycles with a queued instruction
    set_in(1'b1, 4'h6, 4'h1, 4'h2, 1'b1); tick();
    set_in(1'b1, 4'h6, 4'h7, 4'h8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_in_ready", {63'b0, in_ready}, 64'h0);
      chk("stall_val_a", val_a, 64'h1);
      chk("stall_val_b", val_b, 64'h2);
    end
    set_in(1'b1, 4'h6, 4'h7, 4'h8, 1'b1); tick();
    chk("release_val_a", val_a, 64'h7); chk("release_val_b", val_b, 64'h8);
    set_in(1'b0, 4'h0, 4'h0, 4'h0, 1'b1); tick();
    chk("drain_valid", {63'b0, out_valid}, 64'h0);
    chk("drain_hold_val_a", val_a, 64'h7);

    // invalid icode
    set_in(1'b1, 4'hC, 4'h1, 4'h2, 1'b1); tick();
    chk("inv_err", {63'b0, ins_err}, 64'h1);
    chk("inv_vals", val_a | val_b, 64'h0);

    // reset pulse in the middle of a stall, with a write presented during reset
    set_in(1'b1, 4'h6, 4'h1, 4'h2, 1'b1); tick();
    set_in(1'b1, 4'h6, 4'h3, 4'h3, 1'b0);
    set_wr(1'b1, 4'h3, 64'hBAD, 1'b0, 4'h0, '0); tick();
    set_wr(1'b1, 4'h2, 64'h55, 1'b1, 4'h3, 64'h66);
    #1; rst_n = 1'b0; #1;
    model_reset();
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
    check_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_wr(1'b0, 4'h0, '0, 1'b0, 4'h0, '0);
    set_in(1'b1, 4'h6, 4'h2, 4'h3, 1'b1); tick();
    chk("post_rst_val_a", val_a, 64'h2); chk("post_rst_val_b", val_b, 64'h3);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      set_in($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      set_wr($urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
             $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
